// File: rtl/usr_pkg.sv
// Shared constants for the universal/burst shift register slice.
package usr_pkg;

  // Operation select encoding applied to the current register contents
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  // Burst sequencer states
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

endpackage

// File: rtl/usr_shift_core.sv
// Combinational next-value function of the shift register for one operation.
import usr_pkg::*;

module usr_shift_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             left_serial_i,
  input  logic             right_serial_i,
  output logic [WIDTH-1:0] q_next_o
);

  // Select the next register value from the requested operation
  always_comb begin
    q_next_o = q_i;
    unique case (mode_i)
      MODE_SHR:  q_next_o = {left_serial_i, q_i[WIDTH-1:1]};
      MODE_SHL:  q_next_o = {q_i[WIDTH-2:0], right_serial_i};
      MODE_LOAD: q_next_o = data_i;
      MODE_ROR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_ROL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ASR:  q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      MODE_HOLD: q_next_o = q_i;
      MODE_RSVD: q_next_o = q_i;
      default:   q_next_o = q_i;
    endcase
  end

endmodule

// File: rtl/burst_shift_register.sv
// Universal shift register with a burst sequencer that repeats one
// operation for a programmed number of cycles and flags completion.
import usr_pkg::*;

module burst_shift_register #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             op_valid,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [WIDTH-1:0] data_in,
  input  logic             left_serial_in,
  input  logic             right_serial_in,
  output logic [WIDTH-1:0] q_out,
  output logic             serial_out_lsb,
  output logic             serial_out_msb,
  output logic             busy,
  output logic             done
);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       mode_q,  mode_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic             done_q,  done_d;

  logic [2:0]       core_mode;
  logic [WIDTH-1:0] core_q_next;

  // A burst uses the mode latched at start; IDLE single ops use the live mode
  assign core_mode = (state_q == ST_BURST) ? mode_q : mode;

  usr_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .mode_i         (core_mode),
    .q_i            (q_q),
    .data_i         (data_in),
    .left_serial_i  (left_serial_in),
    .right_serial_i (right_serial_in),
    .q_next_o       (core_q_next)
  );

  // Sequencer: single ops and burst launch in IDLE, counted ops in BURST
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    q_d     = q_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            mode_d  = mode;
            cnt_d   = burst_len;
            state_d = ST_BURST;
          end else begin
            done_d = 1'b1;
          end
        end else if (op_valid) begin
          q_d = core_q_next;
        end
      end
      ST_BURST: begin
        q_d   = core_q_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign q_out          = q_q;
  assign serial_out_lsb = q_q[0];
  assign serial_out_msb = q_q[WIDTH-1];
  assign busy           = (state_q == ST_BURST);
  assign done           = done_q;

endmodule

// File: tb/tb_burst_shift_register.sv
// Randomised and directed checks of burst_shift_register against a
// queue-free behavioural model (remaining-ops counter plus arithmetic ops).
module tb_burst_shift_register;

  localparam int unsigned W = 8;
  localparam int unsigned C = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   mode;
  logic         op_valid;
  logic         start;
  logic [C-1:0] burst_len;
  logic [W-1:0] data_in;
  logic         left_serial_in;
  logic         right_serial_in;
  logic [W-1:0] q_out;
  logic         serial_out_lsb;
  logic         serial_out_msb;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [7:0] m_q;
  int         m_rem;
  logic [2:0] m_mode;
  logic       m_done;

  burst_shift_register #(.WIDTH(W), .CNT_W(C)) dut (
    .clk             (clk),
    .reset           (reset),
    .mode            (mode),
    .op_valid        (op_valid),
    .start           (start),
    .burst_len       (burst_len),
    .data_in         (data_in),
    .left_serial_in  (left_serial_in),
    .right_serial_in (right_serial_in),
    .q_out           (q_out),
    .serial_out_lsb  (serial_out_lsb),
    .serial_out_msb  (serial_out_msb),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] apply(input logic [2:0] m, input logic [7:0] q,
                                       input logic [7:0] d, input logic l, input logic r);
    case (m)
      3'd1:    return (q >> 1) | (l ? 8'h80 : 8'h00);
      3'd2:    return ((q << 1) & 8'hFF) | {7'd0, r};
      3'd3:    return d;
      3'd4:    return (q >> 1) | ((q & 8'h01) << 7);
      3'd5:    return ((q << 1) & 8'hFF) | (q >> 7);
      3'd6:    return (q >> 1) | (q & 8'h80);
      default: return q;
    endcase
  endfunction

  task automatic model_update();
    if (reset) begin
      m_q = 8'h00; m_rem = 0; m_done = 1'b0; m_mode = 3'd0;
    end else if (m_rem > 0) begin
      m_q    = apply(m_mode, m_q, data_in, left_serial_in, right_serial_in);
      m_rem  = m_rem - 1;
      m_done = (m_rem == 0);
    end else begin
      m_done = 1'b0;
      if (start) begin
        if (burst_len != 0) begin
          m_mode = mode;
          m_rem  = int'(burst_len);
        end else begin
          m_done = 1'b1;
        end
      end else if (op_valid) begin
        m_q = apply(mode, m_q, data_in, left_serial_in, right_serial_in);
      end
    end
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare();
    chk("q_out", q_out, m_q);
    chk("lsb", {7'd0, serial_out_lsb}, {7'd0, m_q[0]});
    chk("msb", {7'd0, serial_out_msb}, {7'd0, m_q[7]});
    chk("busy", {7'd0, busy}, {7'd0, m_rem > 0});
    chk("done", {7'd0, done}, {7'd0, m_done});
  endtask

  // One clock: sample inputs into the model at the edge, compare 1 time unit later
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    reset = 1'b0; op_valid = 1'b0; start = 1'b0; mode = 3'd0;
    burst_len = '0; data_in = 8'h00; left_serial_in = 1'b0; right_serial_in = 1'b0;
  endtask

  task automatic op(input logic [2:0] m, input logic [7:0] d);
    op_valid = 1'b1; mode = m; data_in = d;
    step();
    op_valid = 1'b0;
  endtask

  task automatic launch(input logic [2:0] m, input logic [C-1:0] n);
    start = 1'b1; mode = m; burst_len = n;
    step();
    start = 1'b0; mode = 3'd0; burst_len = '0;
  endtask

  logic [7:0] ser_exp;
  logic [7:0] ser_got;

  initial begin
    m_q = 8'h00; m_rem = 0; m_done = 1'b0; m_mode = 3'd0;
    idle_inputs();
    @(negedge clk);

    // Reset wins over a simultaneous load
    reset = 1'b1; op_valid = 1'b1; mode = 3'd3; data_in = 8'hFF;
    step();
    step();
    chk("reset_q", q_out, 8'h00);
    chk("reset_busy", {7'd0, busy}, 8'h00);
    idle_inputs();
    op(3'd3, 8'hA5);
    chk("load", q_out, 8'hA5);

    // Single ops from 0x96 with lsi=1, rsi=0
    left_serial_in = 1'b1; right_serial_in = 1'b0;
    op(3'd3, 8'h96); op(3'd1, 8'h00); chk("shr", q_out, 8'hCB);
    op(3'd3, 8'h96); op(3'd2, 8'h00); chk("shl", q_out, 8'h2C);
    op(3'd3, 8'h96); op(3'd4, 8'h00); chk("ror", q_out, 8'h4B);
    op(3'd3, 8'h96); op(3'd5, 8'h00); chk("rol", q_out, 8'h2D);
    op(3'd3, 8'h96); op(3'd6, 8'h00); chk("asr_neg", q_out, 8'hCB);
    op(3'd3, 8'h16); op(3'd6, 8'h00); chk("asr_pos", q_out, 8'h0B);
    op(3'd3, 8'h96); op(3'd7, 8'h00); chk("rsvd", q_out, 8'h96);
    chk("model_rsvd", m_q, 8'h96);

    // Rotate-left burst of 3 from 0x81
    op(3'd3, 8'h81);
    launch(3'd5, 4'd3);
    chk("rb_busy1", {7'd0, busy}, 8'h01);
    step(); step(); chk("rb_busy3", {7'd0, busy}, 8'h01);
    step();
    chk("rb_q", q_out, 8'h0C);
    chk("rb_done", {7'd0, done}, 8'h01);
    chk("rb_idle", {7'd0, busy}, 8'h00);
    step();
    chk("rb_done_once", {7'd0, done}, 8'h00);

    // Rotate burst of 8 returns to start value
    op(3'd3, 8'h81);
    launch(3'd5, 4'd8);
    for (int i = 0; i < 8; i++) step();
    chk("rot8", q_out, 8'h81);
    step();

    // Serialisation of 0xA5 through the LSB
    left_serial_in = 1'b0;
    op(3'd3, 8'hA5);
    launch(3'd1, 4'd8);
    ser_exp = 8'hA5;
    ser_got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      ser_got[i] = serial_out_lsb;
      step();
    end
    chk("serial_bits", ser_got, ser_exp);
    chk("serial_final", q_out, 8'h00);

    // Zero-length burst: done next cycle, no busy, Q unchanged
    op(3'd3, 8'h5A);
    launch(3'd1, 4'd0);
    chk("len0_done", {7'd0, done}, 8'h01);
    chk("len0_busy", {7'd0, busy}, 8'h00);
    chk("len0_q", q_out, 8'h5A);
    step();

    // Mid-burst start/op_valid ignored; back-to-back start in the done cycle
    op(3'd3, 8'hF0);
    launch(3'd1, 4'd5);
    start = 1'b1; op_valid = 1'b1; mode = 3'd3; data_in = 8'hFF; burst_len = 4'd9;
    step(); step(); step();
    idle_inputs();
    step(); step();
    chk("ignore_q", q_out, 8'h07);
    chk("ignore_done", {7'd0, done}, 8'h01);
    launch(3'd5, 4'd2);
    chk("b2b_busy", {7'd0, busy}, 8'h01);
    step(); step();
    chk("b2b_q", q_out, 8'h1C);
    step();

    // Reset during burst cycle 2 of 5
    op(3'd3, 8'h01);
    launch(3'd2, 4'd5);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_q", q_out, 8'h00);
    chk("abort_busy", {7'd0, busy}, 8'h00);
    step();
    chk("abort_nodone", {7'd0, done}, 8'h00);
    launch(3'd4, 4'd1);
    chk("restart_busy", {7'd0, busy}, 8'h01);
    step();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 63) == 0);
      op_valid        = ($urandom_range(0, 2) == 0);
      start           = ($urandom_range(0, 5) == 0);
      mode            = 3'($urandom_range(0, 7));
      burst_len       = ($urandom_range(0, 3) == 0) ? C'($urandom_range(0, 15)) : C'($urandom_range(0, 3));
      data_in         = 8'($urandom);
      left_serial_in  = 1'($urandom);
      right_serial_in = 1'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
